alarm_snooze_ctrl: RTL and testbench
====================================

// Module: alarm_snooze_ctrl
// PURPOSE
//  Responder to the alarm-match signal produced by the clock's alarm comparator.
//  Turns the raw match level into a managed buzzer with snooze, dismiss, auto-silence and a snooze limit.
//  Sits between the alarm comparator output and the physical Buzz pin of the alarm-clock top.
//  Timing advances only on the 1 Hz tick enable; all logic runs on the single system clock.
// PARAMETERS
//  SNOOZE_S    540  snooze length in ticks (seconds)
//  RING_S      60   maximum ring time in ticks before auto-silence
//  MAX_SNOOZE  3    snoozes allowed per alarm event
// PORTS
//  clk          in   1   system clock; all state updates on posedge
//  rst          in   1   asynchronous, active-high reset
//  tick         in   1   1 Hz enable, high exactly one clk cycle per second
//  alarm_on     in   1   alarm enable switch (level)
//  buzz_in      in   1   alarm comparator match (level, high while time==alarm)
//  snooze_btn   in   1   snooze button, synchronous level
//  dismiss_btn  in   1   dismiss button, synchronous level
//  buzz_out     out  1   buzzer drive; 1 iff state==RING
//  state_out    out  2   IDLE=0, RING=1, SNOOZE=2, DONE=3
//  snooze_left  out  $clog2(MAX_SNOOZE+1)  snoozes remaining
//  timer_out    out  $clog2(SNOOZE_S+1)    snooze seconds remaining (0 outside SNOOZE)
// BEHAVIOUR
//  Reset (async): state=IDLE, buzz_out=0, snooze_left=MAX_SNOOZE, timer_out=0, ring count=0,
//    all edge-detect history regs=0. A buzz_in already high at reset release counts as a rising edge.
//  Edge detect: x_rise = x & ~x_q, with x_q registered each clk, for buzz_in, snooze_btn and dismiss_btn.
//    A held button acts exactly once.
//  All outputs are decoded from registers; an event sampled at edge k is visible after edge k.
//  Priority per cycle: alarm_on==0 > dismiss_rise > snooze_rise > tick timing.
//  Any state, alarm_on==0: next=IDLE, snooze_left=MAX_SNOOZE, timer=0, ring count=0.
//  IDLE: buzz_rise & alarm_on -> RING with ring count=0. Otherwise stay.
//  RING:
//    dismiss_rise -> DONE.
//    snooze_rise & snooze_left>0 -> SNOOZE; timer=SNOOZE_S; snooze_left-=1.
//    snooze_rise & snooze_left==0 -> ignored; stay in RING.
//    tick: ring count+=1. Tick with ring count==RING_S-1 -> DONE (auto-silence).
//  SNOOZE:
//    dismiss_rise -> DONE; timer=0.
//    tick: timer-=1. Tick with timer==1 -> RING; timer=0; ring count=0.
//    snooze_rise is ignored. buzz_in is ignored.
//  DONE: buzz_in==0 -> IDLE with snooze_left=MAX_SNOOZE. Otherwise wait, which blocks re-triggering
//    within the same match minute.
//  Simultaneous dismiss_rise and snooze_rise: dismiss wins.
//  Tick in the same cycle as a button event: the button transition wins and that tick is not counted.
//  Counters saturate by construction: they never wrap. timer_out and the ring count are sized for
//    SNOOZE_S and RING_S.
//  Reset asserted mid-RING or mid-SNOOZE: buzz_out=0 immediately (async); all reset values apply.
// TESTING  (bench params SNOOZE_S=5, RING_S=4, MAX_SNOOZE=2; tick every 4 clks)
//  1. Reset, alarm_on=1, raise buzz_in -> next clk state_out=1 and buzz_out=1.
//     4 ticks later -> state=DONE, buzz_out=0. Drop buzz_in -> IDLE, snooze_left=2.
//  2. Ring, then snooze press -> state=2, timer_out=5, snooze_left=1.
//     After 5 ticks -> state=1, buzz_out=1. Hold the button 20 clks -> only one snooze consumed.
//  3. Snooze twice, then a third snooze press while ringing -> stays RING, snooze_left=0.
//     Dismiss -> DONE. Drop buzz_in -> IDLE, snooze_left=2.
//  4. Ringing, with snooze and dismiss rising in the same clk -> DONE, snooze_left unchanged.
//  5. In SNOOZE with timer_out=3, drop alarm_on -> next clk IDLE, timer_out=0, snooze_left=2;
//     buzz_in high in IDLE with alarm_on=0 -> no ring.
//  6. Assert rst mid-RING, between clk edges -> buzz_out=0 before the next edge;
//     buzz_in held high through reset release -> RING one clk after release.

Source files
------------

// File: rtl/alarm_snooze_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alarm_snooze_ctrl
// Purpose  : Alarm-match responder driving the buzzer, with snooze, dismiss,
//            auto-silence after a maximum ring time and a per-event snooze limit.
// Revision : 1.0  initial release
// ============================================================================
module alarm_snooze_ctrl #(
  parameter int SNOOZE_S   = 540,
  parameter int RING_S     = 60,
  parameter int MAX_SNOOZE = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                tick,
  input  logic                                alarm_on,
  input  logic                                buzz_in,
  input  logic                                snooze_btn,
  input  logic                                dismiss_btn,
  output logic                                buzz_out,
  output logic [1:0]                          state_out,
  output logic [$clog2(MAX_SNOOZE+1)-1:0]     snooze_left,
  output logic [$clog2(SNOOZE_S+1)-1:0]       timer_out
);

  localparam int c_left_w  = $clog2(MAX_SNOOZE + 1);
  localparam int c_timer_w = $clog2(SNOOZE_S + 1);
  localparam int c_ring_w  = $clog2(RING_S + 1);

  localparam logic [c_left_w-1:0]  c_max_left  = c_left_w'(MAX_SNOOZE);
  localparam logic [c_timer_w-1:0] c_snooze_ld = c_timer_w'(SNOOZE_S);
  localparam logic [c_timer_w-1:0] c_timer_one = c_timer_w'(1);
  localparam logic [c_ring_w-1:0]  c_ring_last = c_ring_w'(RING_S - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t                r_state;
  logic [c_left_w-1:0]   r_left;
  logic [c_timer_w-1:0]  r_timer;
  logic [c_ring_w-1:0]   r_ring_cnt;
  logic                  r_buzz_q;
  logic                  r_snz_q;
  logic                  r_dis_q;

  logic w_buzz_rise;
  logic w_snz_rise;
  logic w_dis_rise;

  // History regs clear on reset, so a match already high at release is an edge.
  assign w_buzz_rise = buzz_in     & ~r_buzz_q;
  assign w_snz_rise  = snooze_btn  & ~r_snz_q;
  assign w_dis_rise  = dismiss_btn & ~r_dis_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buzz_q <= 1'b0;
      r_snz_q  <= 1'b0;
      r_dis_q  <= 1'b0;
    end else begin
      r_buzz_q <= buzz_in;
      r_snz_q  <= snooze_btn;
      r_dis_q  <= dismiss_btn;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_left     <= c_max_left;
      r_timer    <= '0;
      r_ring_cnt <= '0;
    end else if (!alarm_on) begin
      r_state    <= ST_IDLE;
      r_left     <= c_max_left;
      r_timer    <= '0;
      r_ring_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_buzz_rise) begin
            r_state    <= ST_RING;
            r_ring_cnt <= '0;
          end
        end
        ST_RING: begin
          // A snooze with no snoozes left is treated as no event at all.
          if (w_dis_rise) begin
            r_state <= ST_DONE;
          end else if (w_snz_rise && (r_left != '0)) begin
            r_state <= ST_SNOOZE;
            r_timer <= c_snooze_ld;
            r_left  <= r_left - 1'b1;
          end else if (tick) begin
            if (r_ring_cnt == c_ring_last) begin
              r_state <= ST_DONE;
            end
            r_ring_cnt <= r_ring_cnt + 1'b1;
          end
        end
        ST_SNOOZE: begin
          if (w_dis_rise) begin
            r_state <= ST_DONE;
            r_timer <= '0;
          end else if (tick) begin
            if (r_timer == c_timer_one) begin
              r_state    <= ST_RING;
              r_timer    <= '0;
              r_ring_cnt <= '0;
            end else if (r_timer != '0) begin
              r_timer <= r_timer - 1'b1;
            end
          end
        end
        ST_DONE: begin
          // Waiting out the match level blocks a re-trigger in the same minute.
          if (!buzz_in) begin
            r_state <= ST_IDLE;
            r_left  <= c_max_left;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign buzz_out    = (r_state == ST_RING);
  assign state_out   = r_state;
  assign snooze_left = r_left;
  assign timer_out   = r_timer;

endmodule
`default_nettype wire

// File: tb/tb_alarm_snooze_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alarm_snooze_ctrl
// Purpose  : Scoreboard bench for alarm_snooze_ctrl (SNOOZE_S=5, RING_S=4,
//            MAX_SNOOZE=2, tick every 4 clocks).
// Revision : 1.0  initial release
// ============================================================================
module tb_alarm_snooze_ctrl;

  localparam int c_idle = 0, c_ring = 1, c_snz = 2, c_done = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       alarm_on = 1'b0;
  logic       buzz_in = 1'b0;
  logic       snooze_btn = 1'b0;
  logic       dismiss_btn = 1'b0;
  logic       buzz_out;
  logic [1:0] state_out;
  logic [1:0] snooze_left;
  logic [2:0] timer_out;

  int n_total = 0;
  int n_bad   = 0;
  int tphase  = 0;
  bit tick_en = 1'b0;
  bit last_tick;

  typedef struct packed {
    logic [1:0] st;
    logic       bz;
    logic [1:0] left;
    logic [2:0] tmr;
  } exp_t;

  string tag_q[$];
  exp_t  exp_q[$];

  alarm_snooze_ctrl #(.SNOOZE_S(5), .RING_S(4), .MAX_SNOOZE(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .alarm_on   (alarm_on),
    .buzz_in    (buzz_in),
    .snooze_btn (snooze_btn),
    .dismiss_btn(dismiss_btn),
    .buzz_out   (buzz_out),
    .state_out  (state_out),
    .snooze_left(snooze_left),
    .timer_out  (timer_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_total++;
    if (obs != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp_v);
    end
  endtask

  function automatic void push(input string tag, input int st, input int bz,
                               input int left, input int tmr);
    exp_t e;
    e.st   = 2'(st);
    e.bz   = 1'(bz);
    e.left = 2'(left);
    e.tmr  = 3'(tmr);
    tag_q.push_back(tag);
    exp_q.push_back(e);
  endfunction

  task automatic drain();
    while (exp_q.size() > 0) begin
      string t;
      exp_t  e;
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      chk({t, ".state"}, int'(state_out),   int'(e.st));
      chk({t, ".buzz"},  int'(buzz_out),    int'(e.bz));
      chk({t, ".left"},  int'(snooze_left), int'(e.left));
      chk({t, ".timer"}, int'(timer_out),   int'(e.tmr));
    end
  endtask

  // One clock: tick is asserted for every fourth edge while enabled.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      tick = tick_en && (tphase == 3);
      last_tick = tick;
      tphase = (tphase + 1) % 4;
      @(posedge clk);
      #1;
      tick = 1'b0;
    end
  endtask

  task automatic ticks(input int n);
    int seen = 0;
    int guard = 0;
    while (seen < n && guard < 100) begin
      cyc(1);
      guard++;
      if (last_tick) seen++;
    end
    if (seen < n) chk("tick_budget", seen, n);
  endtask

  initial begin
    cyc(2);
    push("reset", c_idle, 0, 2, 0);
    drain();
    rst = 1'b0;
    alarm_on = 1'b1;
    tick_en = 1'b1;
    cyc(1);

    // 1: ring then auto-silence after 4 ticks
    push("t1_ring", c_ring, 1, 2, 0);
    buzz_in = 1'b1; cyc(1); drain();
    push("t1_3ticks", c_ring, 1, 2, 0);
    ticks(3); drain();
    push("t1_auto", c_done, 0, 2, 0);
    ticks(1); drain();
    push("t1_idle", c_idle, 0, 2, 0);
    buzz_in = 1'b0; cyc(1); drain();

    // 2: snooze, held button, return to ring
    push("t2_ring", c_ring, 1, 2, 0);
    buzz_in = 1'b1; cyc(1); drain();
    push("t2_snz", c_snz, 0, 1, 5);
    snooze_btn = 1'b1; cyc(1); drain();
    push("t2_tmr1", c_snz, 0, 1, 1);
    ticks(4); drain();
    push("t2_back", c_ring, 1, 1, 0);
    ticks(1); drain();
    push("t2_held", c_ring, 1, 1, 0);
    cyc(2); drain();
    snooze_btn = 1'b0; cyc(1);

    // 3: exhaust snoozes, extra press ignored, dismiss
    push("t3_snz2", c_snz, 0, 0, 5);
    snooze_btn = 1'b1; cyc(1); drain();
    snooze_btn = 1'b0;
    push("t3_back", c_ring, 1, 0, 0);
    ticks(5); drain();
    push("t3_extra", c_ring, 1, 0, 0);
    snooze_btn = 1'b1; cyc(1); drain();
    snooze_btn = 1'b0;
    push("t3_dismiss", c_done, 0, 0, 0);
    dismiss_btn = 1'b1; cyc(1); drain();
    dismiss_btn = 1'b0;
    push("t3_idle", c_idle, 0, 2, 0);
    buzz_in = 1'b0; cyc(1); drain();

    // 4: simultaneous snooze and dismiss
    push("t4_ring", c_ring, 1, 2, 0);
    buzz_in = 1'b1; cyc(1); drain();
    push("t4_both", c_done, 0, 2, 0);
    snooze_btn = 1'b1; dismiss_btn = 1'b1; cyc(1); drain();
    snooze_btn = 1'b0; dismiss_btn = 1'b0;
    push("t4_idle", c_idle, 0, 2, 0);
    buzz_in = 1'b0; cyc(1); drain();

    // 5: alarm switched off mid-snooze
    push("t5_ring", c_ring, 1, 2, 0);
    buzz_in = 1'b1; cyc(1); drain();
    push("t5_snz", c_snz, 0, 1, 5);
    snooze_btn = 1'b1; cyc(1); drain();
    snooze_btn = 1'b0;
    push("t5_tmr3", c_snz, 0, 1, 3);
    ticks(2); drain();
    push("t5_off", c_idle, 0, 2, 0);
    alarm_on = 1'b0; cyc(1); drain();
    buzz_in = 1'b0; cyc(1);
    push("t5_noring", c_idle, 0, 2, 0);
    buzz_in = 1'b1; cyc(2); drain();
    buzz_in = 1'b0; alarm_on = 1'b1; cyc(1);

    // 6: async reset mid-ring, match held through release
    push("t6_ring", c_ring, 1, 2, 0);
    buzz_in = 1'b1; cyc(1); drain();
    #2;
    rst = 1'b1;
    #1;
    push("t6_async", c_idle, 0, 2, 0);
    drain();
    cyc(2);
    rst = 1'b0;
    push("t6_rering", c_ring, 1, 2, 0);
    cyc(1); drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
